// File: rtl/uart_pkg.sv
// Shared UART definitions: baud state encoding, power-up defaults and the
// divisor calculation reused by the TX/RX engines.
package uart_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        PEND = 2'd2
    } uart_state_e;

    localparam int unsigned DEF_REFERENCE_CLOCK = 32'd50_000_000;
    localparam int unsigned DEF_BAUD            = 32'd115_200;
    localparam int unsigned DEF_OVERSAMPLE      = 32'd16;
    localparam int unsigned DEF_NBITS           = 32'd16;

    function automatic int unsigned calc_div(
        input int unsigned ref_clk,
        input int unsigned baud,
        input int unsigned oversample
    );
        return ref_clk / (baud * oversample);
    endfunction

    localparam int unsigned DEF_DIV = calc_div(DEF_REFERENCE_CLOCK, DEF_BAUD, DEF_OVERSAMPLE);

endpackage

// File: rtl/uart_baud_ctrl_if.sv
// Divisor request channel between the register block (master) and the
// baud controller (slave).
interface uart_baud_ctrl_if #(
    parameter int unsigned NBITS = 32'd16
);
    logic [NBITS-1:0] cfg_div;
    logic             cfg_valid;
    logic             cfg_ready;
    logic             cfg_err;

    modport master (
        output cfg_div,
        output cfg_valid,
        input  cfg_ready,
        input  cfg_err
    );

    modport slave (
        input  cfg_div,
        input  cfg_valid,
        output cfg_ready,
        output cfg_err
    );
endinterface

// File: rtl/uart_tick_gen.sv
// Programmable divider plus oversample counter; emits registered one-cycle
// oversample and bit ticks.
module uart_tick_gen
    import uart_pkg::*;
#(
    parameter int unsigned NBITS      = DEF_NBITS,
    parameter int unsigned OVERSAMPLE = DEF_OVERSAMPLE
) (
    input  logic             clk_in,
    input  logic             reset,
    input  logic             clear,
    input  logic             run,
    input  logic [NBITS-1:0] div,
    output logic             tick_os,
    output logic             tick_bit
);
    localparam int unsigned     OS_W    = (OVERSAMPLE > 32'd1) ? $clog2(OVERSAMPLE) : 32'd1;
    localparam logic [OS_W-1:0] OS_LAST = OS_W'(OVERSAMPLE - 32'd1);

    logic [NBITS-1:0] cnt_q, cnt_d;
    logic [OS_W-1:0]  os_cnt_q, os_cnt_d;
    logic             tick_os_q, tick_os_d;
    logic             tick_bit_q, tick_bit_d;
    logic [NBITS-1:0] cnt_last_s;

    // div is never zero here, so div-1 cannot wrap
    assign cnt_last_s = div - NBITS'(32'd1);

    // counter and tick registers
    always_ff @(posedge clk_in) begin
        if (reset) begin
            cnt_q      <= {NBITS{1'b0}};
            os_cnt_q   <= {OS_W{1'b0}};
            tick_os_q  <= 1'b0;
            tick_bit_q <= 1'b0;
        end else begin
            cnt_q      <= cnt_d;
            os_cnt_q   <= os_cnt_d;
            tick_os_q  <= tick_os_d;
            tick_bit_q <= tick_bit_d;
        end
    end

    // next counter values; clear dominates and forces both ticks low
    always_comb begin
        cnt_d      = cnt_q;
        os_cnt_d   = os_cnt_q;
        tick_os_d  = 1'b0;
        tick_bit_d = 1'b0;
        if (clear) begin
            cnt_d    = {NBITS{1'b0}};
            os_cnt_d = {OS_W{1'b0}};
        end else if (run) begin
            if (cnt_q == cnt_last_s) begin
                cnt_d     = {NBITS{1'b0}};
                tick_os_d = 1'b1;
                if (os_cnt_q == OS_LAST) begin
                    os_cnt_d   = {OS_W{1'b0}};
                    tick_bit_d = 1'b1;
                end else begin
                    os_cnt_d = os_cnt_q + OS_W'(32'd1);
                end
            end else begin
                cnt_d = cnt_q + NBITS'(32'd1);
            end
        end else begin
            cnt_d = cnt_q;
        end
    end

    assign tick_os  = tick_os_q;
    assign tick_bit = tick_bit_q;

endmodule

// File: rtl/uart_baud_ctrl.sv
// Baud-tick scheduler: owns the shared divisor, accepts run-time divisor
// requests and swaps them in only while both TX and RX are idle.
module uart_baud_ctrl
    import uart_pkg::*;
#(
    parameter int unsigned REFERENCE_CLOCK = DEF_REFERENCE_CLOCK,
    parameter int unsigned BAUD            = DEF_BAUD,
    parameter int unsigned OVERSAMPLE      = DEF_OVERSAMPLE,
    parameter int unsigned NBITS           = DEF_NBITS,
    parameter int unsigned DEFAULT_DIV     = calc_div(REFERENCE_CLOCK, BAUD, OVERSAMPLE)
) (
    input  logic             clk_in,
    input  logic             reset,
    input  logic             en,
    input  logic             tx_busy,
    input  logic             rx_busy,
    uart_baud_ctrl_if.slave  cfg,
    output logic             tick_os,
    output logic             tick_bit,
    output logic [NBITS-1:0] active_div,
    output logic             cfg_pending
);
    localparam logic [NBITS-1:0] RESET_DIV = NBITS'(DEFAULT_DIV);

    uart_state_e      state_q, state_d;
    logic [NBITS-1:0] active_div_q, active_div_d;
    logic [NBITS-1:0] pend_div_q, pend_div_d;
    logic             cfg_ready_q, cfg_ready_d;
    logic             cfg_err_q, cfg_err_d;
    logic             cfg_pending_q, cfg_pending_d;

    logic             hs_s, hs_zero_s, hs_load_s, apply_s;
    logic             tick_clear_s, tick_run_s;

    assign hs_s      = cfg.cfg_valid & cfg_ready_q;
    assign hs_zero_s = hs_s & (cfg.cfg_div == {NBITS{1'b0}});
    assign hs_load_s = hs_s & (cfg.cfg_div != {NBITS{1'b0}});
    // dropping en releases a held divisor even if a channel still reports busy
    assign apply_s   = (state_q == PEND) & ((~tx_busy & ~rx_busy) | ~en);

    assign tick_clear_s = apply_s | ~en;
    assign tick_run_s   = en & (state_q != IDLE);

    // state and control registers
    always_ff @(posedge clk_in) begin
        if (reset) begin
            state_q       <= IDLE;
            active_div_q  <= RESET_DIV;
            pend_div_q    <= {NBITS{1'b0}};
            cfg_ready_q   <= 1'b1;
            cfg_err_q     <= 1'b0;
            cfg_pending_q <= 1'b0;
        end else begin
            state_q       <= state_d;
            active_div_q  <= active_div_d;
            pend_div_q    <= pend_div_d;
            cfg_ready_q   <= cfg_ready_d;
            cfg_err_q     <= cfg_err_d;
            cfg_pending_q <= cfg_pending_d;
        end
    end

    // next-state logic
    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE: begin
                if (hs_load_s) begin
                    state_d = PEND;
                end else if (en) begin
                    state_d = RUN;
                end else begin
                    state_d = IDLE;
                end
            end
            RUN: begin
                if (hs_load_s) begin
                    state_d = PEND;
                end else if (!en) begin
                    state_d = IDLE;
                end else begin
                    state_d = RUN;
                end
            end
            PEND: begin
                if (apply_s) begin
                    state_d = en ? RUN : IDLE;
                end else begin
                    state_d = PEND;
                end
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    // output and datapath next values
    always_comb begin
        active_div_d = active_div_q;
        pend_div_d   = pend_div_q;
        if (apply_s) begin
            active_div_d = pend_div_q;
        end else begin
            active_div_d = active_div_q;
        end
        if (hs_load_s) begin
            pend_div_d = cfg.cfg_div;
        end else begin
            pend_div_d = pend_div_q;
        end
        cfg_err_d     = hs_zero_s;
        cfg_ready_d   = (state_d != PEND);
        cfg_pending_d = (state_d == PEND);
    end

    uart_tick_gen #(
        .NBITS      (NBITS),
        .OVERSAMPLE (OVERSAMPLE)
    ) u_tick_gen (
        .clk_in   (clk_in),
        .reset    (reset),
        .clear    (tick_clear_s),
        .run      (tick_run_s),
        .div      (active_div_q),
        .tick_os  (tick_os),
        .tick_bit (tick_bit)
    );

    assign active_div    = active_div_q;
    assign cfg_pending   = cfg_pending_q;
    assign cfg.cfg_ready = cfg_ready_q;
    assign cfg.cfg_err   = cfg_err_q;

endmodule

// File: tb/tb_uart_baud_ctrl.sv
// Scoreboard bench for uart_baud_ctrl: a cycle-level reference model predicts
// every output after each edge; a monitor compares on the falling edge.
module tb_uart_baud_ctrl;

    localparam int OS  = 16;
    localparam int DEF = 27;

    typedef struct {
        logic        tos;
        logic        tbit;
        logic [15:0] div;
        logic        rdy;
        logic        pend;
        logic        err;
    } exp_t;

    logic        clk_in = 1'b0;
    logic        reset;
    logic        en;
    logic        tx_busy;
    logic        rx_busy;
    logic        tick_os;
    logic        tick_bit;
    logic [15:0] active_div;
    logic        cfg_pending;

    exp_t exp_q[$];
    int   n_checks = 0;
    int   n_errors = 0;
    int   cyc      = 0;

    // reference model state: divisor in use, held request, idle flag, and
    // the number of divider cycles counted since the last restart
    int   m_act;
    int   m_pend;
    bit   m_has_pend;
    bit   m_idle;
    int   m_n;

    uart_baud_ctrl_if #(.NBITS(16)) cfg_if ();

    uart_baud_ctrl dut (
        .clk_in      (clk_in),
        .reset       (reset),
        .en          (en),
        .tx_busy     (tx_busy),
        .rx_busy     (rx_busy),
        .cfg         (cfg_if),
        .tick_os     (tick_os),
        .tick_bit    (tick_bit),
        .active_div  (active_div),
        .cfg_pending (cfg_pending)
    );

    initial forever #5 clk_in = ~clk_in;

    task automatic model_step();
        exp_t e;
        bit   xfer;
        bit   apply;
        e.tos  = 1'b0;
        e.tbit = 1'b0;
        e.err  = 1'b0;
        if (reset) begin
            m_act      = DEF;
            m_pend     = 0;
            m_has_pend = 1'b0;
            m_idle     = 1'b1;
            m_n        = 0;
        end else begin
            xfer  = cfg_if.cfg_valid && !m_has_pend;
            apply = m_has_pend && ((!tx_busy && !rx_busy) || !en);
            if (apply || !en) begin
                m_n = 0;
            end else if (!m_idle) begin
                m_n++;
                e.tos  = ((m_n % m_act) == 0);
                e.tbit = ((m_n % (m_act * OS)) == 0);
            end
            if (apply) begin
                m_act      = m_pend;
                m_has_pend = 1'b0;
            end
            if (xfer && cfg_if.cfg_div == 16'd0) e.err = 1'b1;
            if (xfer && cfg_if.cfg_div != 16'd0) begin
                m_pend     = int'(cfg_if.cfg_div);
                m_has_pend = 1'b1;
            end
            m_idle = m_has_pend ? 1'b0 : !en;
        end
        e.div  = 16'(m_act);
        e.rdy  = !m_has_pend;
        e.pend = m_has_pend;
        exp_q.push_back(e);
    endtask

    initial forever begin
        @(posedge clk_in);
        model_step();
    end

    // monitor: compare DUT outputs against the oldest prediction
    initial forever begin
        exp_t e;
        @(negedge clk_in);
        cyc++;
        n_checks++;
        if (exp_q.size() == 0) begin
            n_errors++;
            $display("FAIL scoreboard_empty cycle %0d: no prediction available", cyc);
        end else begin
            e = exp_q.pop_front();
            if (tick_os !== e.tos || tick_bit !== e.tbit || active_div !== e.div ||
                cfg_if.cfg_ready !== e.rdy || cfg_pending !== e.pend || cfg_if.cfg_err !== e.err) begin
                n_errors++;
                $display("FAIL outputs cycle %0d: got tos=%b tbit=%b div=%0d rdy=%b pend=%b err=%b, expected tos=%b tbit=%b div=%0d rdy=%b pend=%b err=%b",
                         cyc, tick_os, tick_bit, active_div, cfg_if.cfg_ready, cfg_pending, cfg_if.cfg_err,
                         e.tos, e.tbit, e.div, e.rdy, e.pend, e.err);
            end
        end
    end

    task automatic wait_cyc(input int n);
        repeat (n) @(negedge clk_in);
    endtask

    task automatic request(input logic [15:0] d);
        cfg_if.cfg_div   = d;
        cfg_if.cfg_valid = 1'b1;
        @(negedge clk_in);
        cfg_if.cfg_valid = 1'b0;
    endtask

    initial begin
        reset            = 1'b1;
        en               = 1'b0;
        tx_busy          = 1'b0;
        rx_busy          = 1'b0;
        cfg_if.cfg_valid = 1'b0;
        cfg_if.cfg_div   = 16'd0;
        wait_cyc(3);
        reset = 1'b0;
        wait_cyc(2);

        // default divisor: tick_os every 27, tick_bit every 432
        en = 1'b1;
        wait_cyc(880);
        // idle request: one-cycle ready drop, divisor 3
        request(16'd3);
        wait_cyc(100);
        // busy request waits, old rate continues
        tx_busy = 1'b1;
        request(16'd5);
        wait_cyc(40);
        tx_busy = 1'b0;
        wait_cyc(200);
        // zero divisor is rejected with an error pulse
        request(16'd0);
        wait_cyc(10);
        // pending under rx_busy, en drop applies and idles
        rx_busy = 1'b1;
        request(16'd2);
        wait_cyc(7);
        en = 1'b0;
        wait_cyc(10);
        rx_busy = 1'b0;
        // divisor 1 with en rising on the handshake edge
        en = 1'b1;
        request(16'd1);
        wait_cyc(40);
        // reset while pending mid-count
        tx_busy = 1'b1;
        request(16'd4);
        wait_cyc(5);
        reset = 1'b1;
        wait_cyc(1);
        reset   = 1'b0;
        tx_busy = 1'b0;
        wait_cyc(60);

        // randomized traffic with small divisors so bit ticks occur often
        for (int i = 0; i < 3000; i++) begin
            if ($urandom_range(0, 59) == 0) en = ~en;
            if ($urandom_range(0, 19) == 0) tx_busy = ~tx_busy;
            if ($urandom_range(0, 19) == 0) rx_busy = ~rx_busy;
            reset            = ($urandom_range(0, 499) == 0);
            cfg_if.cfg_valid = ($urandom_range(0, 14) == 0);
            cfg_if.cfg_div   = 16'($urandom_range(0, 6));
            @(negedge clk_in);
        end
        reset            = 1'b0;
        cfg_if.cfg_valid = 1'b0;
        wait_cyc(3);
        #1;
        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

endmodule
